// File: rtl/corepwm_timebase_pkg.sv
// Shared CorePWM definitions: default data/channel widths and small helpers
// used by the timebase and its shadow register banks.
package corepwm_timebase_pkg;

   // Default APB data width, shared with pwm_gen and the register file
   localparam int COREPWM_APB_DWIDTH = 8;

   // Default number of PWM channels
   localparam int COREPWM_PWM_NUM = 8;

   // Decide whether the shadow registers take the live edge values this cycle.
   // With buffering disabled or free-running update they follow every cycle;
   // otherwise they only move on the edge that closes a PWM period.
   function automatic logic shadow_load(
      input logic shadow_en,
      input logic sync_update,
      input logic period_wrap
   );
      logic load;
      if (!shadow_en) begin
         load = 1'b1;
      end else if (!sync_update) begin
         load = 1'b1;
      end else begin
         load = period_wrap;
      end
      return load;
   endfunction

endpackage : corepwm_timebase_pkg

// File: rtl/corepwm_shadow_bank.sv
// One bank of shadow edge registers. Holds its contents until load_i is
// seen, then captures the whole live bank in a single edge.
module corepwm_shadow_bank
   import corepwm_timebase_pkg::*;
#(
   parameter int WIDTH = COREPWM_APB_DWIDTH * COREPWM_PWM_NUM
) (
   input  logic             PCLK,
   input  logic             PRESETN,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next shadow contents: capture on load, otherwise hold
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = data_i;
      end else begin
         data_d = data_q;
      end
   end

   // Shadow storage with asynchronous clear
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         data_q <= {WIDTH{1'b0}};
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule : corepwm_shadow_bank

// File: rtl/corepwm_timebase.sv
// CorePWM timebase: prescaler, period counter, tick/period strobes and the
// posedge/negedge shadow banks that feed pwm_gen.
module corepwm_timebase
   import corepwm_timebase_pkg::*;
#(
   parameter int APB_DWIDTH    = COREPWM_APB_DWIDTH,
   parameter int PWM_NUM       = COREPWM_PWM_NUM,
   parameter int SHADOW_REG_EN = 1
) (
   input  logic                          PCLK,
   input  logic                          PRESETN,
   input  logic                          timebase_en,
   input  logic [APB_DWIDTH-1:0]         prescale_reg,
   input  logic [APB_DWIDTH-1:0]         period_reg,
   input  logic                          sync_update,
   input  logic [PWM_NUM*APB_DWIDTH-1:0] posedge_in,
   input  logic [PWM_NUM*APB_DWIDTH-1:0] negedge_in,
   output logic [APB_DWIDTH-1:0]         period_cnt,
   output logic                          sync_pulse,
   output logic                          period_end,
   output logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg,
   output logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg
);

   localparam int BANK_W = PWM_NUM * APB_DWIDTH;
   localparam logic [APB_DWIDTH-1:0] CNT_ZERO = {APB_DWIDTH{1'b0}};
   localparam logic [APB_DWIDTH-1:0] CNT_ONE  = {{(APB_DWIDTH-1){1'b0}}, 1'b1};

   logic [APB_DWIDTH-1:0] prescale_cnt_q;
   logic [APB_DWIDTH-1:0] prescale_cnt_d;
   logic [APB_DWIDTH-1:0] period_cnt_q;
   logic [APB_DWIDTH-1:0] period_cnt_d;
   logic                  sync_pulse_q;
   logic                  sync_pulse_d;
   logic                  period_end_q;
   logic                  period_end_d;
   logic                  tick_s;
   logic                  wrap_s;
   logic                  shadow_load_s;

   // Terminal detection uses >= so a terminal value lowered below the running
   // count wraps at once instead of rolling through the full counter range.
   assign tick_s = (prescale_cnt_q >= prescale_reg);
   assign wrap_s = (period_cnt_q >= period_reg);

   // Next-state for prescaler, period counter and the two strobes
   always_comb begin
      prescale_cnt_d = prescale_cnt_q;
      period_cnt_d   = period_cnt_q;
      sync_pulse_d   = 1'b0;
      period_end_d   = 1'b0;
      if (!timebase_en) begin
         prescale_cnt_d = CNT_ZERO;
         period_cnt_d   = CNT_ZERO;
         sync_pulse_d   = 1'b0;
         period_end_d   = 1'b0;
      end else if (tick_s) begin
         prescale_cnt_d = CNT_ZERO;
         sync_pulse_d   = 1'b1;
         if (wrap_s) begin
            period_cnt_d = CNT_ZERO;
            period_end_d = 1'b1;
         end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            period_end_d = 1'b0;
         end
      end else begin
         prescale_cnt_d = prescale_cnt_q + CNT_ONE;
         period_cnt_d   = period_cnt_q;
         sync_pulse_d   = 1'b0;
         period_end_d   = 1'b0;
      end
   end

   // Counter and strobe registers; strobes and count share one edge so
   // pwm_gen sees them without skew
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         prescale_cnt_q <= CNT_ZERO;
         period_cnt_q   <= CNT_ZERO;
         sync_pulse_q   <= 1'b0;
         period_end_q   <= 1'b0;
      end else begin
         prescale_cnt_q <= prescale_cnt_d;
         period_cnt_q   <= period_cnt_d;
         sync_pulse_q   <= sync_pulse_d;
         period_end_q   <= period_end_d;
      end
   end

   // Shadow banks load on the same edge that raises period_end, so new edge
   // values start exactly with period_cnt = 0.
   assign shadow_load_s = shadow_load((SHADOW_REG_EN != 0), sync_update, period_end_d);

   corepwm_shadow_bank #(
      .WIDTH (BANK_W)
   ) u_posedge_bank (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .load_i  (shadow_load_s),
      .data_i  (posedge_in),
      .data_o  (pwm_posedge_reg)
   );

   corepwm_shadow_bank #(
      .WIDTH (BANK_W)
   ) u_negedge_bank (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .load_i  (shadow_load_s),
      .data_i  (negedge_in),
      .data_o  (pwm_negedge_reg)
   );

   assign period_cnt = period_cnt_q;
   assign sync_pulse = sync_pulse_q;
   assign period_end = period_end_q;

endmodule : corepwm_timebase

// File: doc/corepwm_timebase.md
CORePWM_TIMEBASE -- requirements
Module: corepwm_timebase

Interface
REQ-001 Parameter APB_DWIDTH, default 8: width of prescale, period, count and edge-register fields.
REQ-002 Parameter PWM_NUM, default 8: number of channels whose edge registers are shadowed.
REQ-003 Parameter SHADOW_REG_EN, default 1: 1 = edge registers double-buffered; 0 = edge registers pass through registered every cycle.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-006 PRESETN  in  1  asynchronous active-low reset.
REQ-007 timebase_en  in  1  global enable; 0 holds the counters cleared.
REQ-008 prescale_reg  in  APB_DWIDTH  prescale terminal value; the tick period is prescale_reg+1 PCLK cycles.
REQ-009 period_reg  in  APB_DWIDTH  period terminal value; the PWM period is period_reg+1 ticks.
REQ-010 sync_update  in  1  1 = shadow transfer occurs only at period end; 0 = shadow transfer occurs every cycle.
REQ-011 posedge_in, negedge_in  in  PWM_NUM*APB_DWIDTH each  live (APB-written) edge registers.
REQ-012 period_cnt  out  APB_DWIDTH  current period count, for pwm_gen.
REQ-013 sync_pulse  out  1  one-cycle tick strobe, for pwm_gen.
REQ-014 period_end  out  1  one-cycle strobe on the cycle period_cnt wraps to 0.
REQ-015 pwm_posedge_reg, pwm_negedge_reg  out  PWM_NUM*APB_DWIDTH each  shadowed edge registers, for pwm_gen.

Function
REQ-016 The prescale counter SHALL increment each PCLK while timebase_en=1, and on the cycle it is >= prescale_reg it SHALL clear to 0 at the next edge.
REQ-017 At that same edge, sync_pulse SHALL be registered high for exactly one cycle; otherwise sync_pulse SHALL be 0.
REQ-018 At the edge that asserts sync_pulse, period_cnt SHALL advance: it SHALL clear to 0 if it is >= period_reg, and increment by 1 otherwise.
REQ-019 sync_pulse and the new period_cnt value SHALL therefore be visible in the same cycle, with no skew between them.
REQ-020 period_end SHALL be 1 exactly in the cycle where sync_pulse=1 and period_cnt has just wrapped to 0.
REQ-021 With prescale_reg=0, sync_pulse SHALL be high every cycle while timebase_en=1.
REQ-022 With period_reg=0, period_cnt SHALL remain 0 and period_end SHALL accompany every sync_pulse.
REQ-023 Lowering prescale_reg or period_reg below the current count SHALL cause a wrap on the next terminal evaluation, with no 2^APB_DWIDTH roll-around.
REQ-024 When timebase_en=0, both counters, sync_pulse and period_end SHALL be 0 at the next edge.
REQ-025 When timebase_en returns to 1, counting SHALL restart from 0; the first sync_pulse SHALL occur prescale_reg+1 cycles later.
REQ-026 Shadow transfer when SHADOW_REG_EN=1 and sync_update=1: the shadow outputs SHALL load posedge_in/negedge_in at the edge that produces period_end, so new values take effect with period_cnt=0.
REQ-027 Shadow transfer when sync_update=0 or SHADOW_REG_EN=0: the shadow outputs SHALL load the inputs every cycle, with 1-cycle latency.
REQ-028 While timebase_en=0 and sync_update=1, the shadow outputs SHALL hold their value.
REQ-029 All arithmetic SHALL be unsigned at APB_DWIDTH bits; comparisons SHALL use >= so that no counter overflow is possible.

Reset
REQ-030 While PRESETN=0, the prescale counter, period_cnt, sync_pulse, period_end, pwm_posedge_reg and pwm_negedge_reg SHALL all be 0, asynchronously.
REQ-031 Reset asserted mid-period SHALL discard all counts; after release, behaviour SHALL be identical to power-up.

Structure
REQ-032 APB_DWIDTH and PWM_NUM defaults SHALL live in the shared corepwm parameter include used by pwm_gen and the register file.
REQ-033 The shadow bank SHALL be one sub-module, corepwm_shadow_bank, instantiated once for posedge and once for negedge; all counters SHALL reside in the top level.

Verification
REQ-034 The bench SHALL drive prescale_reg=2, period_reg=3, en=1 and check sync_pulse every 3rd cycle, period_cnt sequence 1,2,3,0,1, and period_end with each 0.
REQ-035 The bench SHALL drive prescale_reg=0, period_reg=0 and check sync_pulse and period_end continuously 1, with period_cnt stuck at 0.
REQ-036 The bench SHALL drive sync_update=1 and write posedge_in ch1 0x05 to 0x0A at period_cnt=1, and check that the output stays 0x05 until the period_end cycle, then reads 0x0A.
REQ-037 The bench SHALL drive sync_update=0, change negedge_in, and check that the output follows after exactly 1 cycle.
REQ-038 The bench SHALL run with period_cnt=7 and period_reg changed 9 to 4, and check that the next sync_pulse gives period_cnt=0 with period_end=1.
REQ-039 The bench SHALL pulse PRESETN low for 1 cycle mid-count, and check that all outputs are 0 immediately and the first sync_pulse comes prescale_reg+1 cycles after release.
